// File: rtl/gemm_pkg.sv
// Shared types and defaults for the GEMM command queue.
package gemm_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    EXEC
  } gemm_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] rs1;
    logic [XLEN_DEF-1:0] rs2;
  } gemm_cmd_t;

endpackage

// File: rtl/gemm_cmd_fifo.sv
// Circular command buffer: storage, wrapping pointers and occupancy count.
// Head data reads as zero while empty so stale slots never leak onto the bus.
module gemm_cmd_fifo
  import gemm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = 3 * XLEN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and count update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gemm_cmd_queue.sv
// GEMM command queue: buffers core commands and issues them one at a time
// to the systolic-array accelerator, tracking completion for busy/fence.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// ISSUE | head offered to accelerator (acc_valid high)
// EXEC  | one command accepted, waiting for acc_done
module gemm_cmd_queue
  import gemm_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [XLEN-1:0] cmd_instr,
  input  logic [XLEN-1:0] cmd_rs1,
  input  logic [XLEN-1:0] cmd_rs2,
  output logic            cmd_ready,
  output logic            acc_valid,
  output logic [XLEN-1:0] acc_instr,
  output logic [XLEN-1:0] acc_rs1,
  output logic [XLEN-1:0] acc_rs2,
  input  logic            acc_ready,
  input  logic            acc_done,
  input  logic            fence_req,
  output logic            busy,
  output logic            fence_stall,
  output logic            proto_err
);

  gemm_state_e       state;
  gemm_state_e       state_nxt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [3*XLEN-1:0] head;

  gemm_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (3 * XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_instr, cmd_rs1, cmd_rs2}),
    .pop       (acc_valid & acc_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // No bypass: readiness comes only from registered occupancy.
  assign cmd_ready   = ~fifo_full;
  assign acc_instr   = head[3*XLEN-1:2*XLEN];
  assign acc_rs1     = head[2*XLEN-1:XLEN];
  assign acc_rs2     = head[XLEN-1:0];
  assign busy        = ~fifo_empty | (state != IDLE);
  assign fence_stall = fence_req & busy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and issue strobe.
  always_comb begin
    state_nxt = state;
    acc_valid = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) state_nxt = ISSUE;
      ISSUE: begin
        acc_valid = 1'b1;
        if (acc_ready) state_nxt = EXEC;
      end
      EXEC:  if (acc_done) state_nxt = fifo_empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky flag for completions that arrive with nothing in flight.
  always_ff @(posedge clk) begin
    if (rst)                            proto_err <= 1'b0;
    else if (acc_done && state != EXEC) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_gemm_cmd_queue.sv
// Directed bench for gemm_cmd_queue with a scoreboard of expected issue order.
module tb_gemm_cmd_queue;
  import gemm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_instr = '0;
  logic [31:0] cmd_rs1 = '0;
  logic [31:0] cmd_rs2 = '0;
  logic        cmd_ready;
  logic        acc_valid;
  logic [31:0] acc_instr;
  logic [31:0] acc_rs1;
  logic [31:0] acc_rs2;
  logic        acc_ready = 1'b0;
  logic        acc_done = 1'b0;
  logic        fence_req = 1'b0;
  logic        busy;
  logic        fence_stall;
  logic        proto_err;

  int total = 0;
  int bad   = 0;
  gemm_cmd_t exp_q[$];

  gemm_cmd_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_instr(cmd_instr), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_ready(cmd_ready),
    .acc_valid(acc_valid), .acc_instr(acc_instr), .acc_rs1(acc_rs1), .acc_rs2(acc_rs2),
    .acc_ready(acc_ready), .acc_done(acc_done), .fence_req(fence_req),
    .busy(busy), .fence_stall(fence_stall), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the oldest expected command.
  always @(negedge clk) begin
    if (!rst && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", acc_instr, 32'hDEAD_DEAD);
      end else begin
        gemm_cmd_t e;
        e = exp_q.pop_front();
        chk("sb_instr", acc_instr, e.instr);
        chk("sb_rs1", acc_rs1, e.rs1);
        chk("sb_rs2", acc_rs2, e.rs2);
      end
    end
  end

  task automatic push_cmd(input logic [31:0] i, input logic [31:0] r1,
                          input logic [31:0] r2, input bit accept);
    gemm_cmd_t c;
    c.instr = i; c.rs1 = r1; c.rs2 = r2;
    cmd_valid = 1'b1; cmd_instr = i; cmd_rs1 = r1; cmd_rs2 = r2;
    if (accept) exp_q.push_back(c);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!acc_valid && n < 20) begin
      tick();
      n++;
    end
    chk("acc_valid_seen", acc_valid, 1);
  endtask

  task automatic run_one(input int delay);
    wait_valid();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    repeat (delay) tick();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fence_stall", fence_stall, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_acc_instr", acc_instr, 0);

    // Single command: valid exactly two cycles after push
    push_cmd(32'h0000_100B, 32'h10, 32'h20, 1);
    chk("single_valid_n1", acc_valid, 0);
    chk("single_busy_n1", busy, 1);
    tick();
    chk("single_valid_n2", acc_valid, 1);
    chk("single_instr", acc_instr, 32'h0000_100B);
    chk("single_rs1", acc_rs1, 32'h10);
    chk("single_rs2", acc_rs2, 32'h20);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("single_exec_valid", acc_valid, 0);
    repeat (4) tick();
    chk("single_busy_exec", busy, 1);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("single_busy_fall", busy, 0);

    // Fill: 5 back-to-back pushes, accelerator stalled
    for (int i = 0; i < 5; i++) begin
      chk("fill_cmd_ready", cmd_ready, (i < 4) ? 1 : 0);
      push_cmd(32'h2000 + i, 32'h100 + i, 32'h200 + i, i < 4);
    end
    chk("fill_full", cmd_ready, 0);
    for (int i = 0; i < 4; i++) run_one(1);
    tick();
    chk("fill_fifth_dropped_busy", busy, 0);
    chk("fill_fifth_dropped_valid", acc_valid, 0);

    // Wrap-around: 10 commands with immediate ready/done
    for (int i = 0; i < 10; i++) begin
      push_cmd(32'h3000 + i, 32'h300 + i, 32'h400 + i, 1);
      run_one(0);
    end
    tick();
    chk("wrap_idle", busy, 0);

    // Simultaneous push and pop at count = 2
    push_cmd(32'h4000, 32'h1, 32'h2, 1);
    push_cmd(32'h4001, 32'h3, 32'h4, 1);
    wait_valid();
    cmd_valid = 1'b1; cmd_instr = 32'h4002; cmd_rs1 = 32'h5; cmd_rs2 = 32'h6;
    exp_q.push_back('{instr: 32'h4002, rs1: 32'h5, rs2: 32'h6});
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    cmd_valid = 1'b0;
    push_cmd(32'h4003, 32'h7, 32'h8, 1);
    chk("simul_count3_ready", cmd_ready, 1);
    push_cmd(32'h4004, 32'h9, 32'hA, 1);
    chk("simul_count4_ready", cmd_ready, 0);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    for (int i = 0; i < 4; i++) run_one(0);
    tick();
    chk("simul_drained", busy, 0);

    // Fence with 3 queued commands
    for (int i = 0; i < 3; i++) push_cmd(32'h5000 + i, 32'h50 + i, 32'h60 + i, 1);
    fence_req = 1'b1;
    #1;
    chk("fence_stall_on", fence_stall, 1);
    run_one(2);
    chk("fence_stall_after1", fence_stall, 1);
    run_one(2);
    chk("fence_stall_after2", fence_stall, 1);
    run_one(2);
    chk("fence_stall_released", fence_stall, 0);
    fence_req = 1'b0;

    // Protocol error: acc_done while IDLE is sticky
    chk("err_pre", proto_err, 0);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("err_set", proto_err, 1);
    chk("err_state_idle", busy, 0);
    push_cmd(32'h6000, 32'h61, 32'h62, 1);
    run_one(1);
    repeat (2) tick();
    chk("err_sticky", proto_err, 1);

    // Reset mid-EXEC with 2 commands still queued
    for (int i = 0; i < 3; i++) push_cmd(32'h7000 + i, 32'h70 + i, 32'h80 + i, 1);
    wait_valid();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    chk("pre_rst_exec", acc_valid, 0);
    rst = 1'b1;
    fence_req = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_acc_valid", acc_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fence_stall", fence_stall, 0);
    chk("mid_rst_proto_err", proto_err, 0);
    chk("mid_rst_acc_instr", acc_instr, 0);
    rst = 1'b0;
    fence_req = 1'b0;
    repeat (3) tick();
    chk("post_rst_discarded", busy, 0);
    chk("post_rst_no_issue", acc_valid, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
